id_ram_scanner: RTL and testbench

//  Read-side sequencer for the 32x24 sprite/object ID RAM. On start it walks addresses
//  0..count-1 through the RAM's 1-cycle synchronous read port and streams each entry,

---
 rtl/id_scan_pkg.sv | 20 ++
 rtl/id_scan_skid.sv | 59 +++++
 rtl/id_ram_scanner.sv | 121 ++++++++++++
 tb/tb_id_ram_scanner.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_scan_pkg.sv
// Shared types and sizes for the ID RAM read-side scanner.
package id_scan_pkg;

    localparam int DW    = 24;  // ID RAM entry width
    localparam int AW    = 5;   // ID RAM address width
    localparam int ACT_B = 23;  // entry "active" flag bit
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } scan_state_t;

    typedef struct packed {
        logic [AW-1:0] index;
        logic [DW-1:0] data;
    } id_beat_t;

endpackage

// File: rtl/id_scan_skid.sv
// Two-entry beat buffer between the RAM read return and the valid/ready output.
// head is always the oldest beat and drives the outputs straight from flops.
module id_scan_skid
    import id_scan_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  id_beat_t   push_beat,
    input  logic       pop,
    output logic [1:0] occ,
    output logic       out_valid,
    output id_beat_t   out_beat
);

    id_beat_t head;
    id_beat_t spare;

    // Occupancy-driven push/pop; the issuer guarantees no push into a full,
    // non-popping buffer, so a third slot is never needed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ   <= 2'd0;
            head  <= '0;
            spare <= '0;
        end else begin
            case (occ)
                2'd0: begin
                    if (push) begin
                        head <= push_beat;
                        occ  <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({push, pop})
                        2'b11: head <= push_beat;
                        2'b01: occ  <= 2'd0;
                        2'b10: begin
                            spare <= push_beat;
                            occ   <= 2'd2;
                        end
                        default: ;
                    endcase
                end
                default: begin
                    if (pop) begin
                        head <= spare;
                        if (push) spare <= push_beat;
                        else      occ   <= 2'd1;
                    end
                end
            endcase
        end
    end

    assign out_valid = (occ != 2'd0);
    assign out_beat  = head;

endmodule

// File: rtl/id_ram_scanner.sv
// Read-side sequencer for the 32x24 ID RAM: walks addresses 0..count-1 through
// the 1-cycle synchronous read port and streams {index,data} beats downstream.
// Build option ID_SCAN_SKIP_EMPTY_EN: entries whose active bit is clear are
// dropped at capture (they still use a read slot and a counter step).
module id_ram_scanner
    import id_scan_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW:0]   count,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_index
);

    scan_state_t   state;
    logic [AW:0]   cnt_q;      // sampled scan length
    logic [AW:0]   issued;     // reads issued so far this scan
    logic [AW:0]   issued_nx;
    logic          inflight;   // a read is returning on rd_data this cycle
    logic [AW-1:0] idx_q;      // address of the returning read
    logic [1:0]    occ;
    logic [2:0]    slots;
    logic          pop;
    logic          push;
    logic          issue;
    logic          drain_empty;
    id_beat_t      push_beat;
    id_beat_t      head_beat;

    assign pop       = out_valid & out_ready;
    assign issued_nx = issued + 1'b1;

    // A slot freed by this cycle's pop counts as free, which is what lets a
    // steady ready stream run at one beat per cycle.
    assign slots = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign issue = (state == ISSUE) && (slots < 3'd2);

    // Last beat leaves this cycle and nothing is returning behind it.
    assign drain_empty = !inflight && ((occ == 2'd0) || (occ == 2'd1 && pop));

`ifdef ID_SCAN_SKIP_EMPTY_EN
    assign push = inflight & rd_data[ACT_B];
`else
    assign push = inflight;
`endif

    assign push_beat = '{index: idx_q, data: rd_data};

    // Scan FSM with address/issue counters, in-flight tracking and registered
    // busy/done; done is raised as the FSM returns to IDLE so a start in the
    // done cycle is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_addr  <= '0;
            cnt_q    <= '0;
            issued   <= '0;
            inflight <= 1'b0;
            idx_q    <= '0;
        end else begin
            done     <= 1'b0;
            inflight <= issue;
            if (issue) idx_q <= rd_addr;
            if (done)  busy  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count == '0) begin
                            done <= 1'b1;
                        end else begin
                            state   <= ISSUE;
                            busy    <= 1'b1;
                            cnt_q   <= count;
                            issued  <= '0;
                            rd_addr <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        issued <= issued_nx;
                        // hold on the last address rather than stepping past it
                        if (issued_nx == cnt_q) state   <= DRAIN;
                        else                    rd_addr <= rd_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_empty) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    id_scan_skid u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_beat (push_beat),
        .pop       (pop),
        .occ       (occ),
        .out_valid (out_valid),
        .out_beat  (head_beat)
    );

    assign out_data  = head_beat.data;
    assign out_index = head_beat.index;

endmodule

// File: tb/tb_id_ram_scanner.sv
// Self-checking bench for id_ram_scanner: RAM model, ready patterns, and a
// reference list of expected beats built directly from RAM contents and count.
module tb_id_ram_scanner;
    import id_scan_pkg::*;

    localparam int CW = AW + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW:0]   count;
    logic          busy;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_index;

    id_ram_scanner dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ID RAM: 1-cycle synchronous read
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) rd_data <= mem[rd_addr];

    // downstream ready: 0 = always, 1 = 1,0,0,1,0,1 repeating, 2 = random
    int rmode = 0;
    int rpos  = 0;
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: out_ready = 1'b1;
            1: begin
                out_ready = (rpos == 0) || (rpos == 3) || (rpos == 5);
                rpos = (rpos == 5) ? 0 : rpos + 1;
            end
            default: out_ready = ($urandom_range(0, 9) < 6);
        endcase
    end

    // observation of the output stream
    logic [AW-1:0] got_idx [$];
    logic [DW-1:0] got_dat [$];
    int hold_bad = 0, vld_cycles = 0, busy_cycles = 0;
    int vld_rise_cyc = -1, last_beat_cyc = -1;
    logic stall_q = 1'b0, vld_q = 1'b0;
    logic [AW-1:0] hold_idx;
    logic [DW-1:0] hold_dat;
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_q && !(out_valid && out_index == hold_idx && out_data == hold_dat))
                hold_bad++;
            if (out_valid && !vld_q) vld_rise_cyc = cyc;
            if (out_valid) vld_cycles++;
            if (busy) busy_cycles++;
            if (out_valid && out_ready) begin
                got_idx.push_back(out_index);
                got_dat.push_back(out_data);
                last_beat_cyc = cyc;
            end
            stall_q  = out_valid && !out_ready;
            hold_idx = out_index;
            hold_dat = out_data;
            vld_q    = out_valid;
        end else begin
            stall_q = 1'b0;
            vld_q   = 1'b0;
        end
    end

    int errs = 0, checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model: every address below n in order, minus inactive ones
    // when the skip option is built in
    int            exp_idx [$];
    logic [DW-1:0] exp_dat [$];
    task automatic build_exp(input int n);
        exp_idx.delete();
        exp_dat.delete();
        for (int i = 0; i < n; i++) begin
`ifdef ID_SCAN_SKIP_EMPTY_EN
            if (!mem[i][ACT_B]) continue;
`endif
            exp_idx.push_back(i);
            exp_dat.push_back(mem[i]);
        end
    endtask

    task automatic compare_scan(input string tag, input int base);
        int n;
        n = got_idx.size() - base;
        chk({tag, "_nbeats"}, 32'(n), 32'(exp_idx.size()));
        for (int k = 0; k < n && k < exp_idx.size(); k++) begin
            chk({tag, "_index"}, 32'(got_idx[base+k]), 32'(exp_idx[k]));
            chk({tag, "_data"},  32'(got_dat[base+k]), 32'(exp_dat[k]));
        end
    endtask

    task automatic pulse_start(input int n, output int t);
        @(posedge clk); #1;
        start = 1'b1;
        count = CW'(n);
        t     = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int d);
        d = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) begin
                d = cyc;
                break;
            end
        end
        if (d < 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic fill_random(input bit odd_inactive);
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = DW'($urandom);
            if (odd_inactive) mem[i][ACT_B] = ~i[0];
        end
    endtask

    initial begin
        int t0, d, base, bc, vc, nd, n;
        rst_n = 1'b0;
        start = 1'b0;
        count = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = {1'b1, 23'(i)};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_addr", 32'(rd_addr), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_index", 32'(out_index), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // full 32-entry scan with ready held high: latency and throughput
        rmode = 0;
        build_exp(32);
        base = got_idx.size();
        pulse_start(32, t0);
        @(negedge clk);
        chk("t1_addr0", 32'(rd_addr), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_done(100, d);
        chk("t1_first_valid", 32'(vld_rise_cyc - t0), 32'd3);
        chk("t1_last_beat", 32'(last_beat_cyc - t0), 32'd34);
        chk("t1_done_lat", 32'(d - t0), 32'd35);
        chk("t1_busy_at_done", 32'(busy), 32'd1);
        compare_scan("t1", base);
        @(negedge clk);
        chk("t1_busy_off", 32'(busy), 32'd0);

        // count 0: done next cycle, no busy, no beats
        bc = busy_cycles;
        vc = vld_cycles;
        base = got_idx.size();
        pulse_start(0, t0);
        wait_done(10, d);
        chk("t2_done_lat", 32'(d - t0), 32'd1);
        chk("t2_busy", 32'(busy_cycles - bc), 32'd0);
        chk("t2_valid", 32'(vld_cycles - vc), 32'd0);
        chk("t2_nbeats", 32'(got_idx.size() - base), 32'd0);

        // count 8 under a stalling ready pattern
        fill_random(1'b0);
        rmode = 1;
        build_exp(8);
        base = got_idx.size();
        pulse_start(8, t0);
        wait_done(200, d);
        compare_scan("t3", base);
        chk("t3_hold", 32'(hold_bad), 32'd0);

        // start mid-scan ignored; start in the done cycle accepted
        rmode = 0;
        build_exp(10);
        base = got_idx.size();
        pulse_start(10, t0);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        count = CW'(3);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(100, d);
        compare_scan("t4a", base);
        start = 1'b1;
        count = CW'(4);
        build_exp(4);
        base = got_idx.size();
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("t4_restart_addr", 32'(rd_addr), 32'd0);
        chk("t4_restart_busy", 32'(busy), 32'd1);
        wait_done(100, d);
        compare_scan("t4b", base);

        // reset mid-scan aborts without done; next scan restarts at 0
        fill_random(1'b0);
        build_exp(32);
        base = got_idx.size();
        pulse_start(32, t0);
        for (int i = 0; i < 200 && (got_idx.size() - base) < 10; i++) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = got_idx.size() - base;
        for (int k = 0; k < n && k < exp_idx.size(); k++)
            chk("t5_pre_index", 32'(got_idx[base+k]), 32'(exp_idx[k]));
        @(negedge clk);
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        nd = 0;
        base = got_idx.size();
        repeat (40) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("t5_no_done", 32'(nd), 32'd0);
        chk("t5_no_beats", 32'(got_idx.size() - base), 32'd0);
        build_exp(32);
        base = got_idx.size();
        pulse_start(32, t0);
        wait_done(100, d);
        compare_scan("t5", base);

        // inactive entries at odd addresses
        fill_random(1'b1);
        build_exp(32);
        base = got_idx.size();
        pulse_start(32, t0);
        wait_done(100, d);
`ifdef ID_SCAN_SKIP_EMPTY_EN
        chk("t6_count", 32'(exp_idx.size()), 32'd16);
`else
        chk("t6_count", 32'(exp_idx.size()), 32'd32);
`endif
        compare_scan("t6", base);

        // random contents, lengths and ready
        rmode = 2;
        for (int r = 0; r < 6; r++) begin
            fill_random(1'b0);
            n = $urandom_range(0, DEPTH);
            build_exp(n);
            base = got_idx.size();
            pulse_start(n, t0);
            wait_done(400, d);
            compare_scan("rnd", base);
        end
        chk("hold_stable", 32'(hold_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
